// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo path: drain FSM state encoding and
// the ASCII control characters used by the optional CR->CRLF expansion.
// Optional feature macro: UART_CRLF_EN (adds the S_LF state).
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3
`ifdef UART_CRLF_EN
        ,
        S_LF    = 3'd4
`endif
    } drain_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. rd_data shows the head entry
// whenever the FIFO is not empty. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate flag.
module sync_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]  wr_ptr_r;
    logic [ADDR_W:0]  rd_ptr_r;
    logic [ADDR_W:0]  count_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    logic full_s;
    logic empty_s;
    logic do_rd_s;
    logic do_wr_s;

    assign full_s  = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                     (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);

    // A read only happens when there is data; a write into a full FIFO is
    // only accepted when a read frees the head slot in the same cycle.
    assign do_rd_s = rd_en & ~empty_s;
    assign do_wr_s = wr_en & (~full_s | do_rd_s);

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(ADDR_W+1){1'b0}};
            rd_ptr_r <= {(ADDR_W+1){1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + PTR_ONE;
                2'b01:   count_r <= count_r - PTR_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r[ADDR_W-1:0]];
    assign full    = full_s;
    assign empty   = empty_s;
    assign count   = count_r;

endmodule

// File: rtl/uart_echo_buffer.sv
// Elastic buffer between uart_rx and uart_tx in the echo path. Received bytes
// are queued in a FWFT FIFO; a drain FSM pops them one at a time and pulses
// tx_start, pacing itself on tx_busy.
// Optional feature macro: UART_CRLF_EN -- every transmitted CR is followed by
// an inserted LF (the LF itself is never expanded).
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              tx_busy,
    input  logic              ovf_clr,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic [7:0]        last_byte
);

    drain_state_t state_r;
    drain_state_t state_next_s;

    logic            pop_s;
    logic            drop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [7:0]      fifo_head_s;
    logic [ADDR_W:0] fifo_count_s;
`ifdef UART_CRLF_EN
    logic            load_lf_s;
`endif

    logic            tx_start_r;
    logic [7:0]      tx_data_r;
    logic            overflow_r;
    logic [7:0]      last_byte_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_ready),
        .wr_data (rx_data),
        .rd_en   (pop_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // A byte is lost only when the FIFO is full and no pop frees a slot.
    assign drop_s = rx_ready & fifo_full_s & ~pop_s;

    // Drain FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Drain FSM next-state and pop decision.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
`ifdef UART_CRLF_EN
        load_lf_s    = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = S_START;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_START: begin
                state_next_s = S_ARM;
            end
            S_ARM: begin
                // uart_tx raises busy one cycle after sampling tx_start.
                state_next_s = S_WAIT;
            end
            S_WAIT: begin
                if (!tx_busy) begin
`ifdef UART_CRLF_EN
                    if (tx_data_r == ASCII_CR) begin
                        state_next_s = S_LF;
                    end else begin
                        state_next_s = S_IDLE;
                    end
`else
                    state_next_s = S_IDLE;
`endif
                end else begin
                    state_next_s = S_WAIT;
                end
            end
`ifdef UART_CRLF_EN
            S_LF: begin
                load_lf_s    = 1'b1;
                state_next_s = S_START;
            end
`endif
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // tx_start is registered so it is high exactly while the FSM sits in S_START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_start_r <= 1'b0;
        end else begin
            tx_start_r <= (state_next_s == S_START);
        end
    end

    // Transmit byte: loaded on a pop (or inserted LF), then held through the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_r <= 8'h00;
        end else if (pop_s) begin
            tx_data_r <= fifo_head_s;
`ifdef UART_CRLF_EN
        end else if (load_lf_s) begin
            tx_data_r <= ASCII_LF;
`endif
        end else begin
            tx_data_r <= tx_data_r;
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Most recent received byte, updated even when the byte is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_byte_r <= 8'h00;
        end else if (rx_ready) begin
            last_byte_r <= rx_data;
        end else begin
            last_byte_r <= last_byte_r;
        end
    end

    assign tx_start   = tx_start_r;
    assign tx_data    = tx_data_r;
    assign fifo_count = fifo_count_s;
    assign overflow   = overflow_r;
    assign last_byte  = last_byte_r;

endmodule
